// File: rtl/fetch_unit.sv
// Fetch unit: program counter, branch-target adder, instruction register and a
// two-state instruction-memory read sequencer with timeout. Optional macro FETCH_BR_COUNT_EN adds br_count.
module fetch_unit #(
    parameter int unsigned PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned TIMEOUT  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_write,
    input  logic            pc_sel,
    input  logic            br_sel,
    input  logic            ir_load,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_rvalid,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    output logic [PC_W-1:0] pc_out,
    output logic [31:0]     ir_out,
    output logic [3:0]      opcode,
    output logic [3:0]      mm,
    output logic            fetch_stall,
`ifdef FETCH_BR_COUNT_EN
    output logic [15:0]     br_count,
`endif
    output logic            fetch_err
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [7:0]      cnt_reg, cnt_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic [PC_W-1:0] addr_reg, addr_next;
    logic [31:0]     ir_reg, ir_next;
    logic            err_reg, err_next;

    logic [PC_W-1:0] br_off;
    logic [PC_W-1:0] br_abs;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_rel;

    // Immediate field mapped onto PC_W bits: sign-extended for relative
    // targets, zero-extended for absolute ones, truncated when PC_W < 16.
    generate
        for (genvar gi = 0; gi < PC_W; gi++) begin : g_imm
            if (gi < 16) begin : g_low
                assign br_off[gi] = ir_reg[gi];
                assign br_abs[gi] = ir_reg[gi];
            end else begin : g_high
                assign br_off[gi] = ir_reg[15];
                assign br_abs[gi] = 1'b0;
            end
        end
    endgenerate

    assign pc_inc = pc_reg + {{(PC_W-1){1'b0}}, 1'b1};
    assign pc_rel = pc_reg + br_off;

    always_comb begin
        pc_next = pc_reg;
        if (pc_write) begin
            if (!pc_sel)
                pc_next = pc_inc;
            else if (br_sel)
                pc_next = br_abs;
            else
                pc_next = pc_rel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 8'd0;
            pc_reg    <= RESET_PC;
            addr_reg  <= RESET_PC;
            ir_reg    <= 32'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            pc_reg    <= pc_next;
            addr_reg  <= addr_next;
            ir_reg    <= ir_next;
            err_reg   <= err_next;
        end
    end

    // Returned data wins over a timeout that expires in the same cycle.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        ir_next    = ir_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (ir_load) begin
                    addr_next  = pc_reg;
                    cnt_next   = 8'(TIMEOUT);
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    ir_next    = imem_rdata;
                    cnt_next   = 8'd0;
                    state_next = IDLE;
                end else if (cnt_reg <= 8'd1) begin
                    ir_next    = 32'd0;
                    err_next   = 1'b1;
                    cnt_next   = 8'd0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef FETCH_BR_COUNT_EN
    logic [15:0] br_count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            br_count_reg <= 16'd0;
        else if (pc_write && pc_sel && (br_count_reg != 16'hFFFF))
            br_count_reg <= br_count_reg + 16'd1;
    end

    assign br_count = br_count_reg;
`endif

    assign imem_req    = (state_reg == WAIT);
    assign fetch_stall = (state_reg == WAIT);
    assign imem_addr   = addr_reg;
    assign pc_out      = pc_reg;
    assign ir_out      = ir_reg;
    assign opcode      = ir_reg[31:28];
    assign mm          = ir_reg[27:24];
    assign fetch_err   = err_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (RESET_PC=0x0010, TIMEOUT=8).
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_write, pc_sel, br_sel, ir_load;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic        imem_req;
    logic [15:0] imem_addr, pc_out;
    logic [31:0] ir_out;
    logic [3:0]  opcode, mm;
    logic        fetch_stall, fetch_err;
`ifdef FETCH_BR_COUNT_EN
    logic [15:0] br_count;
    int          br_expected = 0;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_unit #(.PC_W(16), .RESET_PC(16'h0010), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .pc_write(pc_write), .pc_sel(pc_sel), .br_sel(br_sel), .ir_load(ir_load),
        .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
        .imem_req(imem_req), .imem_addr(imem_addr), .pc_out(pc_out),
        .ir_out(ir_out), .opcode(opcode), .mm(mm), .fetch_stall(fetch_stall),
`ifdef FETCH_BR_COUNT_EN
        .br_count(br_count),
`endif
        .fetch_err(fetch_err)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    // Loads the IR through a one-cycle-latency fetch; leaves inputs idle.
    task automatic do_fetch(input logic [31:0] data);
        ir_load = 1'b1;
        tick();
        ir_load = 1'b0; imem_rvalid = 1'b1; imem_rdata = data;
        tick();
        imem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pc_write = 0; pc_sel = 0; br_sel = 0; ir_load = 0;
        imem_rdata = 32'd0; imem_rvalid = 0;
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++; if (pc_out !== 16'h0010) begin failures++; $display("FAIL reset_pc actual=%h expected=0010", pc_out); end
        checks++; if (ir_out !== 32'd0) begin failures++; $display("FAIL reset_ir actual=%h expected=00000000", ir_out); end
        checks++; if (imem_req !== 1'b0 || fetch_stall !== 1'b0 || fetch_err !== 1'b0) begin
            failures++; $display("FAIL reset_flags actual req=%b stall=%b err=%b expected 0 0 0", imem_req, fetch_stall, fetch_err); end
        checks++; if (imem_addr !== 16'h0010) begin failures++; $display("FAIL reset_addr actual=%h expected=0010", imem_addr); end
        $display("reset: pc=%h ir=%h addr=%h", pc_out, ir_out, imem_addr);
    endtask

    task automatic test_fetch_basic();
        ir_load = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1 || fetch_stall !== 1'b1) begin
            failures++; $display("FAIL basic_req actual req=%b stall=%b expected 1 1", imem_req, fetch_stall); end
        checks++; if (imem_addr !== 16'h0010) begin failures++; $display("FAIL basic_addr actual=%h expected=0010", imem_addr); end
        ir_load = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h81000123;
        tick();
        imem_rvalid = 1'b0;
        checks++; if (fetch_stall !== 1'b0 || imem_req !== 1'b0) begin
            failures++; $display("FAIL basic_stall_len actual stall=%b req=%b expected 0 0", fetch_stall, imem_req); end
        checks++; if (ir_out !== 32'h81000123) begin failures++; $display("FAIL basic_ir actual=%h expected=81000123", ir_out); end
        checks++; if (opcode !== 4'h8 || mm !== 4'h1) begin
            failures++; $display("FAIL basic_fields actual op=%h mm=%h expected 8 1", opcode, mm); end
        $display("fetch: addr=10 ir=%h op=%h mm=%h", ir_out, opcode, mm);
    endtask

    task automatic test_pc_update();
        tick();
        checks++; if (pc_out !== 16'h0010) begin failures++; $display("FAIL pc_hold actual=%h expected=0010", pc_out); end
        pc_write = 1'b1; pc_sel = 1'b0;
        tick();
        pc_write = 1'b0;
        checks++; if (pc_out !== 16'h0011) begin failures++; $display("FAIL pc_inc actual=%h expected=0011", pc_out); end
        $display("pc_update: pc=%h", pc_out);
    endtask

    task automatic test_wrap();
        do_fetch(32'h0000FFFF);
        pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b1;
        tick();
`ifdef FETCH_BR_COUNT_EN
        br_expected++;
`endif
        checks++; if (pc_out !== 16'hFFFF) begin failures++; $display("FAIL wrap_setup actual=%h expected=ffff", pc_out); end
        pc_sel = 1'b0;
        tick();
        pc_write = 1'b0;
        checks++; if (pc_out !== 16'h0000) begin failures++; $display("FAIL wrap actual=%h expected=0000", pc_out); end
        $display("wrap: pc=%h", pc_out);
    endtask

    task automatic test_branch();
        do_fetch(32'h00000020);
        pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b1;
        tick(); pc_write = 1'b0;
        checks++; if (pc_out !== 16'h0020) begin failures++; $display("FAIL br_abs20 actual=%h expected=0020", pc_out); end
        do_fetch(32'h0000FFFC);
        pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b0;
        tick(); pc_write = 1'b0;
        checks++; if (pc_out !== 16'h001C) begin failures++; $display("FAIL br_rel_neg actual=%h expected=001c", pc_out); end
        pc_write = 1'b1; br_sel = 1'b1;
        tick(); pc_write = 1'b0;
        checks++; if (pc_out !== 16'hFFFC) begin failures++; $display("FAIL br_abs actual=%h expected=fffc", pc_out); end
        do_fetch(32'h00000010);
        pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b0;
        tick(); pc_write = 1'b0; pc_sel = 1'b0;
        checks++; if (pc_out !== 16'h000C) begin failures++; $display("FAIL br_rel_pos actual=%h expected=000c", pc_out); end
`ifdef FETCH_BR_COUNT_EN
        br_expected += 4;
        checks++; if (br_count !== 16'(br_expected)) begin
            failures++; $display("FAIL br_count actual=%0d expected=%0d", br_count, br_expected); end
`endif
        $display("branch: pc=%h", pc_out);
    endtask

    task automatic test_same_edge();
        ir_load = 1'b1; pc_write = 1'b1; pc_sel = 1'b0;
        tick();
        ir_load = 1'b0; pc_write = 1'b0;
        checks++; if (imem_addr !== 16'h000C) begin failures++; $display("FAIL same_edge_addr actual=%h expected=000c", imem_addr); end
        checks++; if (pc_out !== 16'h000D) begin failures++; $display("FAIL same_edge_pc actual=%h expected=000d", pc_out); end
        imem_rvalid = 1'b1; imem_rdata = 32'h12345678;
        tick();
        imem_rvalid = 1'b0;
        checks++; if (ir_out !== 32'h12345678) begin failures++; $display("FAIL same_edge_ir actual=%h expected=12345678", ir_out); end
        $display("same_edge: addr=%h pc=%h ir=%h", imem_addr, pc_out, ir_out);
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        bit ended = 0;
        ir_load = 1'b1;
        tick();
        ir_load = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req !== 1'b1) begin ended = 1; break; end
            req_cycles++;
            tick();
        end
        checks++; if (!ended) begin failures++; $display("FAIL timeout_bound actual=req_stuck expected=req_low_within_20"); end
        checks++; if (req_cycles != 8) begin failures++; $display("FAIL timeout_len actual=%0d expected=8", req_cycles); end
        checks++; if (ir_out !== 32'd0 || fetch_err !== 1'b1) begin
            failures++; $display("FAIL timeout_noop actual ir=%h err=%b expected 00000000 1", ir_out, fetch_err); end
        do_fetch(32'hA5000001);
        checks++; if (ir_out !== 32'hA5000001 || fetch_err !== 1'b1) begin
            failures++; $display("FAIL err_sticky actual ir=%h err=%b expected a5000001 1", ir_out, fetch_err); end
        $display("timeout: req_cycles=%0d err=%b", req_cycles, fetch_err);
    endtask

    task automatic test_back_to_back();
        int rises = 0;
        logic prev_req = 1'b0;
        ir_load = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            if (imem_req && !prev_req) rises++;
            prev_req = imem_req;
            checks++; if (imem_addr !== 16'h000D || imem_req !== 1'b1) begin
                failures++; $display("FAIL b2b_hold%0d actual addr=%h req=%b expected 000d 1", k, imem_addr, imem_req); end
            pc_write = (k == 0);
            pc_sel = 1'b0;
            if (k == 2) begin imem_rvalid = 1'b1; imem_rdata = 32'h3C00BEEF; end
            tick();
        end
        ir_load = 1'b0; imem_rvalid = 1'b0; pc_write = 1'b0;
        checks++; if (ir_out !== 32'h3C00BEEF) begin failures++; $display("FAIL b2b_ir actual=%h expected=3c00beef", ir_out); end
        checks++; if (pc_out !== 16'h000E) begin failures++; $display("FAIL b2b_pc actual=%h expected=000e", pc_out); end
        tick();
        if (imem_req && !prev_req) rises++;
        checks++; if (imem_req !== 1'b0 || rises != 1) begin
            failures++; $display("FAIL b2b_single_req actual req=%b rises=%0d expected 0 1", imem_req, rises); end
        $display("back_to_back: ir=%h rises=%0d", ir_out, rises);
    endtask

    task automatic test_reset_mid_fetch();
        ir_load = 1'b1;
        tick();
        ir_load = 1'b0;
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rstmid_pre actual req=%b expected 1", imem_req); end
        #2 rst = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0 || fetch_stall !== 1'b0) begin
            failures++; $display("FAIL rstmid_async actual req=%b stall=%b expected 0 0", imem_req, fetch_stall); end
        checks++; if (pc_out !== 16'h0010 || fetch_err !== 1'b0) begin
            failures++; $display("FAIL rstmid_pc actual pc=%h err=%b expected 0010 0", pc_out, fetch_err); end
        imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
        tick();
        rst = 1'b0;
        tick();
        imem_rvalid = 1'b0;
        checks++; if (ir_out !== 32'd0 || imem_req !== 1'b0) begin
            failures++; $display("FAIL rstmid_late actual ir=%h req=%b expected 00000000 0", ir_out, imem_req); end
        $display("reset_mid_fetch: pc=%h ir=%h", pc_out, ir_out);
    endtask

    initial begin
        test_reset();
        test_fetch_basic();
        test_pc_update();
        test_wrap();
        test_branch();
        test_same_edge();
        test_timeout();
        test_back_to_back();
        test_reset_mid_fetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
